// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and loads
// the IF/ID register with the fetched word and its PC+4, honouring redirects and stalls.
module fetch_stage #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_instr,
  output logic [WORD_WIDTH-1:0] if_instr,
  output logic [WORD_WIDTH-1:0] if_pc_plus4,
  output logic                  if_valid
);

  localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

  logic [WORD_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] pc_next;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
    return {addr[WORD_WIDTH-1:2], 2'b00};
  endfunction

  // Sequential PC increment; wraps modulo 2^WORD_WIDTH.
  function automatic logic [WORD_WIDTH-1:0] pc_incr(input logic [WORD_WIDTH-1:0] addr);
    return addr + PC_STEP;
  endfunction

  assign pc_next   = pc_incr(pc);
  assign imem_addr = pc;

  // PC and IF/ID register: redirect beats freeze beats advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
      if_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc          <= word_align(branch_addr);
      if_instr    <= '0;
      if_pc_plus4 <= '0;
      if_valid    <= 1'b0;
    end else if (!freeze) begin
      pc          <= pc_next;
      if_instr    <= imem_instr;
      if_pc_plus4 <= pc_next;
      if_valid    <= 1'b1;
    end
  end

endmodule
